// File: rtl/decodificador_numero_if.sv
// Character-in / BCD-number-out bundle between a character source and the number decoder.
interface decodificador_numero_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [3:0] miles;
    logic [3:0] centenas;
    logic [3:0] decenas;
    logic [3:0] unidades;
    logic [3:0] decimal;
    logic       num_valid;
    logic       num_ack;
    logic       err;

    modport master (
        output char_in, char_valid, num_ack,
        input  char_ready, miles, centenas, decenas, unidades, decimal, num_valid, err
    );

    modport slave (
        input  char_in, char_valid, num_ack,
        output char_ready, miles, centenas, decenas, unidades, decimal, num_valid, err
    );
endinterface

// File: rtl/decodificador_numero.sv
// Parses "dddd.d<CR>" character frames into BCD integer digits plus a fraction in sixteenths.
module decodificador_numero #(
    parameter logic [7:0] CHAR_ZERO = 8'h30,
    parameter logic [7:0] CHAR_DOT  = 8'h2E,
    parameter logic [7:0] CHAR_END  = 8'h0D
) (
    input  logic                         clk,
    input  logic                         rst_n,
    decodificador_numero_if.slave        num_if
);

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 3;

    localparam logic [2:0] IDLE          = 3'd0;
    localparam logic [2:0] ENTERO        = 3'd1;
    localparam logic [2:0] FRACCION_PEND = 3'd2;
    localparam logic [2:0] FRACCION      = 3'd3;
    localparam logic [2:0] DESCARTE      = 3'd4;
    localparam logic [2:0] LISTO         = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] w_mil_q, w_mil_d, w_cen_q, w_cen_d, w_dec_q, w_dec_d, w_uni_q, w_uni_d;
    logic [DW-1:0] w_frac_q, w_frac_d;
    logic [CW-1:0] int_cnt_q, int_cnt_d;
    logic [DW-1:0] o_mil_q, o_mil_d, o_cen_q, o_cen_d, o_dec_q, o_dec_d, o_uni_q, o_uni_d;
    logic [DW-1:0] o_frac_q, o_frac_d;
    logic          num_valid_q, num_valid_d;
    logic          err_q, err_d;
    logic          char_ready_q, char_ready_d;

    logic          accept, is_digit, is_dot, is_end;
    logic [DW-1:0] digit;

    // One decimal digit rounded to the nearest sixteenth
    function automatic logic [DW-1:0] sixteenths(input logic [DW-1:0] d);
        case (d)
            4'd0:    sixteenths = 4'd0;
            4'd1:    sixteenths = 4'd2;
            4'd2:    sixteenths = 4'd3;
            4'd3:    sixteenths = 4'd5;
            4'd4:    sixteenths = 4'd6;
            4'd5:    sixteenths = 4'd8;
            4'd6:    sixteenths = 4'd10;
            4'd7:    sixteenths = 4'd11;
            4'd8:    sixteenths = 4'd13;
            4'd9:    sixteenths = 4'd14;
            default: sixteenths = 4'd0;
        endcase
    endfunction

    always_comb begin
        accept   = num_if.char_valid && char_ready_q;
        is_digit = (num_if.char_in >= CHAR_ZERO) && (num_if.char_in <= 8'(CHAR_ZERO + 8'd9));
        is_dot   = (num_if.char_in == CHAR_DOT);
        is_end   = (num_if.char_in == CHAR_END);
        digit    = DW'(num_if.char_in - CHAR_ZERO);
    end

    // Next-state and datapath: working registers track the frame, output registers load on CR
    always_comb begin
        state_d     = state_q;
        w_mil_d     = w_mil_q;
        w_cen_d     = w_cen_q;
        w_dec_d     = w_dec_q;
        w_uni_d     = w_uni_q;
        w_frac_d    = w_frac_q;
        int_cnt_d   = int_cnt_q;
        o_mil_d     = o_mil_q;
        o_cen_d     = o_cen_q;
        o_dec_d     = o_dec_q;
        o_uni_d     = o_uni_q;
        o_frac_d    = o_frac_q;
        num_valid_d = num_valid_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: if (accept) begin
                if (is_digit || is_dot) begin
                    w_mil_d   = '0;
                    w_cen_d   = '0;
                    w_dec_d   = '0;
                    w_uni_d   = is_digit ? digit : '0;
                    w_frac_d  = '0;
                    int_cnt_d = is_digit ? CW'(1) : '0;
                    state_d   = is_digit ? ENTERO : FRACCION_PEND;
                end else begin
                    err_d   = 1'b1;
                    state_d = is_end ? IDLE : DESCARTE;
                end
            end
            ENTERO: if (accept) begin
                if (is_digit && int_cnt_q < CW'(4)) begin
                    w_mil_d   = w_cen_q;
                    w_cen_d   = w_dec_q;
                    w_dec_d   = w_uni_q;
                    w_uni_d   = digit;
                    int_cnt_d = int_cnt_q + CW'(1);
                end else if (is_dot) begin
                    state_d = FRACCION_PEND;
                end else if (is_end) begin
                    state_d = LISTO;
                end else begin
                    err_d   = 1'b1;
                    state_d = DESCARTE;
                end
            end
            FRACCION_PEND: if (accept) begin
                if (is_digit) begin
                    w_frac_d = sixteenths(digit);
                    state_d  = FRACCION;
                end else if (is_end) begin
                    state_d = LISTO;
                end else begin
                    err_d   = 1'b1;
                    state_d = DESCARTE;
                end
            end
            FRACCION: if (accept) begin
                if (is_end) begin
                    state_d = LISTO;
                end else begin
                    err_d   = 1'b1;
                    state_d = DESCARTE;
                end
            end
            DESCARTE: if (accept && is_end) state_d = IDLE;
            LISTO: if (num_if.num_ack) begin
                num_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == LISTO && state_q != LISTO) begin
            o_mil_d     = w_mil_q;
            o_cen_d     = w_cen_q;
            o_dec_d     = w_dec_q;
            o_uni_d     = w_uni_q;
            o_frac_d    = w_frac_q;
            num_valid_d = 1'b1;
        end

        char_ready_d = (state_d != LISTO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            w_mil_q      <= '0;
            w_cen_q      <= '0;
            w_dec_q      <= '0;
            w_uni_q      <= '0;
            w_frac_q     <= '0;
            int_cnt_q    <= '0;
            o_mil_q      <= '0;
            o_cen_q      <= '0;
            o_dec_q      <= '0;
            o_uni_q      <= '0;
            o_frac_q     <= '0;
            num_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            char_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            w_mil_q      <= w_mil_d;
            w_cen_q      <= w_cen_d;
            w_dec_q      <= w_dec_d;
            w_uni_q      <= w_uni_d;
            w_frac_q     <= w_frac_d;
            int_cnt_q    <= int_cnt_d;
            o_mil_q      <= o_mil_d;
            o_cen_q      <= o_cen_d;
            o_dec_q      <= o_dec_d;
            o_uni_q      <= o_uni_d;
            o_frac_q     <= o_frac_d;
            num_valid_q  <= num_valid_d;
            err_q        <= err_d;
            char_ready_q <= char_ready_d;
        end
    end

    assign num_if.char_ready = char_ready_q;
    assign num_if.miles      = o_mil_q;
    assign num_if.centenas   = o_cen_q;
    assign num_if.decenas    = o_dec_q;
    assign num_if.unidades   = o_uni_q;
    assign num_if.decimal    = o_frac_q;
    assign num_if.num_valid  = num_valid_q;
    assign num_if.err        = err_q;

endmodule

// File: tb/tb_decodificador_numero.sv
// Directed bench for decodificador_numero: one task per scenario, inline checks.
module tb_decodificador_numero;

    localparam logic [7:0] CR = 8'h0D;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [20:0] obs;

    always #5 clk = ~clk;

    decodificador_numero_if bus ();

    decodificador_numero dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .num_if (bus)
    );

    always_comb obs = {bus.miles, bus.centenas, bus.decenas, bus.unidades, bus.decimal, bus.num_valid};

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        bus.char_valid = 1'b0;
        bus.num_ack    = 1'b1;
        @(posedge clk);
        #1;
        bus.num_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        bus.num_ack    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 21'd0);
        end
        checks++;
        if (bus.char_ready !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_err: got ready=%b err=%b expected ready=1 err=0", bus.char_ready, bus.err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send("1"); send("2"); send("3"); send("."); send("5"); send(CR);
        @(negedge clk);
        checks++;
        if (obs !== {4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 1'b1}) begin
            errors++;
            $display("FAIL basic_123_5: got %h expected %h", obs, {4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 1'b1});
        end
        ack();
        @(negedge clk);
        checks++;
        if (obs !== {4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 1'b0} || bus.char_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_after_ack: got %h ready=%b expected %h ready=1", obs, bus.char_ready,
                     {4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 1'b0});
        end
    endtask

    task automatic test_max_hold();
        send("9"); send("9"); send("9"); send("9"); send("."); send("9"); send(CR);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== {4'd9, 4'd9, 4'd9, 4'd9, 4'd14, 1'b1} || bus.char_ready !== 1'b0) begin
                errors++;
                $display("FAIL max_hold[%0d]: got %h ready=%b expected %h ready=0", i, obs, bus.char_ready,
                         {4'd9, 4'd9, 4'd9, 4'd9, 4'd14, 1'b1});
            end
            bus.char_in    = "5";
            bus.char_valid = 1'b1;
        end
        ack();
        @(negedge clk);
        checks++;
        if (bus.num_valid !== 1'b0 || bus.char_ready !== 1'b1) begin
            errors++;
            $display("FAIL max_after_ack: got nv=%b ready=%b expected nv=0 ready=1", bus.num_valid, bus.char_ready);
        end
        // The '5' shown while holding must not have been consumed, so CR lands in IDLE
        send(CR);
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1 || bus.num_valid !== 1'b0) begin
            errors++;
            $display("FAIL listo_no_consume: got err=%b nv=%b expected err=1 nv=0", bus.err, bus.num_valid);
        end
    endtask

    task automatic test_short_frames();
        send("."); send(CR);
        @(negedge clk);
        checks++;
        if (obs !== {16'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL leading_dot: got %h expected %h", obs, {16'd0, 4'd0, 1'b1});
        end
        ack();
        send("7"); send(CR);
        @(negedge clk);
        checks++;
        if (obs !== {4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_7: got %h expected %h", obs, {4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 1'b1});
        end
        ack();
        send("0"); send("."); send("2"); send(CR);
        @(negedge clk);
        checks++;
        if (obs !== {4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL frac_0_2: got %h expected %h", obs, {4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 1'b1});
        end
        ack();
    endtask

    task automatic test_overflow();
        send("1"); send("2"); send("3"); send("4"); send("5");
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_err: got %b expected 1", bus.err);
        end
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL overflow_err_pulse: got %b expected 0", bus.err);
        end
        send(CR);
        @(negedge clk);
        checks++;
        if (obs !== {4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL overflow_hold: got %h expected %h", obs, {4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0});
        end
    endtask

    task automatic test_bad_char();
        send("4"); send("A");
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL bad_char_err: got %b expected 1", bus.err);
        end
        send(CR);
        @(negedge clk);
        checks++;
        if (bus.num_valid !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL discard_cr: got nv=%b err=%b expected nv=0 err=0", bus.num_valid, bus.err);
        end
        send("6"); send(CR);
        @(negedge clk);
        checks++;
        if (obs !== {4'd0, 4'd0, 4'd0, 4'd6, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL after_discard: got %h expected %h", obs, {4'd0, 4'd0, 4'd0, 4'd6, 4'd0, 1'b1});
        end
        ack();
    endtask

    task automatic test_other_errors();
        send(CR);
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL idle_cr_err: got %b expected 1", bus.err);
        end
        send("2"); send(CR);
        @(negedge clk);
        checks++;
        if (obs !== {4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL idle_cr_stays_idle: got %h expected %h", obs, {4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 1'b1});
        end
        ack();
        send("1"); send("."); send(".");
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL second_dot_err: got %b expected 1", bus.err);
        end
        send(CR);
        send("."); send("1"); send("2");
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL second_frac_err: got %b expected 1", bus.err);
        end
        send(CR);
        @(negedge clk);
        checks++;
        if (obs !== {4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL errors_hold: got %h expected %h", obs, {4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        send("5"); send("5");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 21'd0 || bus.char_ready !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got %h ready=%b err=%b expected 0 ready=1 err=0", obs, bus.char_ready, bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send("3"); send(CR);
        @(negedge clk);
        checks++;
        if (obs !== {4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL after_mid_reset: got %h expected %h", obs, {4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 1'b1});
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_hold();
        test_short_frames();
        test_overflow();
        test_bad_char();
        test_other_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
